// File: rtl/mtimer_pkg.sv
// rtl/mtimer_pkg.sv - register map constants and byte-merge helper for mtimer_bank
package mtimer_pkg;

  localparam int MAX_CMP = 8;

  localparam logic [7:0] OFF_MTIME  = 8'h00;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_CMP    = 8'h20;
  localparam logic [7:0] OFF_RELOAD = 8'h60;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 16;

  // Replace only the enabled byte lanes of cur with the matching lanes of wdata.
  function automatic logic [63:0] merge_bytes(input logic [63:0] cur,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  be);
    logic [63:0] res;
    res = cur;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_channel.sv
// rtl/mtimer_channel.sv - one compare channel: mtimecmp, reload, pending and registered interrupt
module mtimer_channel (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] mtime_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  be_i,
  input  logic        cmp_wr_i,
  input  logic        reload_wr_i,
  input  logic        clr_i,
  output logic [63:0] cmp_o,
  output logic [63:0] reload_o,
  output logic        pending_o,
  output logic        mti_o
);
  import mtimer_pkg::*;

  logic [63:0] cmp_q, cmp_d;
  logic [63:0] reload_q, reload_d;
  logic        pending_q, pending_d;
  logic        mti_q, mti_d;
  logic        hit;
  logic        periodic;

  always_comb begin
    hit      = (mtime_i >= cmp_q);
    periodic = (reload_q != 64'd0);

    cmp_d = cmp_q;
    if (cmp_wr_i) begin
      cmp_d = merge_bytes(cmp_q, wdata_i, be_i);
    end else if (periodic && hit) begin
      cmp_d = cmp_q + reload_q;
    end

    reload_d = reload_wr_i ? merge_bytes(reload_q, wdata_i, be_i) : reload_q;

    // Priority low to high: W1C, hit-set, compare rewrite.
    pending_d = pending_q;
    if (clr_i) pending_d = 1'b0;
    if (periodic && hit) pending_d = 1'b1;
    if (cmp_wr_i) pending_d = 1'b0;

    mti_d = periodic ? pending_q : hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q     <= '1;
      reload_q  <= '0;
      pending_q <= 1'b0;
      mti_q     <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      reload_q  <= reload_d;
      pending_q <= pending_d;
      mti_q     <= mti_d;
    end
  end

  assign cmp_o     = cmp_q;
  assign reload_o  = reload_q;
  assign pending_o = pending_q;
  assign mti_o     = mti_q;

endmodule

// File: rtl/mtimer_bank.sv
// rtl/mtimer_bank.sv - prescaled 64-bit mtime with a bank of compare channels behind a byte-enabled register bus
module mtimer_bank #(
  parameter int NUM_CMP    = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [7:0]         addr_i,
  input  logic [7:0]         we_i,
  input  logic [63:0]        data_i,
  output logic [63:0]        data_o,
  output logic [NUM_CMP-1:0] mti_o,
  output logic [63:0]        mtime_o
);
  import mtimer_pkg::*;

  localparam logic [4:0] SLOT_MTIME  = OFF_MTIME[7:3];
  localparam logic [4:0] SLOT_CTRL   = OFF_CTRL[7:3];
  localparam logic [4:0] SLOT_STATUS = OFF_STATUS[7:3];
  localparam logic [4:0] SLOT_CMP    = OFF_CMP[7:3];
  localparam logic [4:0] SLOT_RELOAD = OFF_RELOAD[7:3];

  logic [4:0]            slot;
  logic                  wr_en, rd_en;
  logic                  wr_mtime, wr_ctrl, wr_status;
  logic [7:0]            be_eff;
  logic [63:0]           wd_eff;
  logic [1:0]            unused_addr;

  logic [63:0]           mtime_q, mtime_d;
  logic [PRESCALE_W-1:0] div_cnt_q, div_cnt_d;
  logic [PRESCALE_W-1:0] ctrl_div_q, ctrl_div_d;
  logic                  ctrl_en_q, ctrl_en_d;
  logic [63:0]           data_q, data_d;
  logic                  tick;

  logic [63:0]           ctrl_val, status_val, rd_val;
  logic [63:0]           cmp_val    [NUM_CMP];
  logic [63:0]           reload_val [NUM_CMP];
  logic [NUM_CMP-1:0]    pending, mti, cmp_wr, reload_wr, clr_bits;

  assign slot        = addr_i[7:3];
  assign unused_addr = addr_i[1:0];
  assign wr_en       = en_i && (we_i != 8'd0);
  assign rd_en       = en_i && (we_i == 8'd0);
  assign wr_mtime    = wr_en && (slot == SLOT_MTIME);
  assign wr_ctrl     = wr_en && (slot == SLOT_CTRL);
  assign wr_status   = wr_en && (slot == SLOT_STATUS);

  // Upper-half accesses carry their data in the low 32 bits; steer it onto lanes 7..4.
  assign be_eff = addr_i[2] ? {we_i[3:0], 4'b0000} : we_i;
  assign wd_eff = addr_i[2] ? {data_i[31:0], 32'd0} : data_i;

  assign clr_bits = (wr_status && be_eff[0]) ? wd_eff[NUM_CMP-1:0] : '0;

  assign tick = ctrl_en_q && (div_cnt_q == ctrl_div_q);

  always_comb begin
    div_cnt_d = div_cnt_q;
    mtime_d   = mtime_q;
    if (ctrl_en_q) begin
      div_cnt_d = tick ? '0 : div_cnt_q + PRESCALE_W'(1);
      if (tick) mtime_d = mtime_q + 64'd1;
    end
    if (wr_ctrl)  div_cnt_d = '0;
    if (wr_mtime) mtime_d   = merge_bytes(mtime_q, wd_eff, be_eff);
  end

  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    ctrl_div_d = ctrl_div_q;
    if (wr_ctrl) begin
      if (be_eff[CTRL_EN_BIT/8]) ctrl_en_d = wd_eff[CTRL_EN_BIT];
      for (int j = 0; j < PRESCALE_W; j++) begin
        if (be_eff[(CTRL_DIV_LSB+j)/8]) ctrl_div_d[j] = wd_eff[CTRL_DIV_LSB+j];
      end
    end
  end

  always_comb begin
    ctrl_val                               = '0;
    ctrl_val[CTRL_EN_BIT]                  = ctrl_en_q;
    ctrl_val[CTRL_DIV_LSB +: PRESCALE_W]   = ctrl_div_q;
    status_val                             = '0;
    status_val[NUM_CMP-1:0]                = pending;
  end

  always_comb begin
    rd_val = '0;
    case (slot)
      SLOT_MTIME:  rd_val = mtime_q;
      SLOT_CTRL:   rd_val = ctrl_val;
      SLOT_STATUS: rd_val = status_val;
      default:     rd_val = '0;
    endcase
    for (int i = 0; i < NUM_CMP; i++) begin
      if (slot == SLOT_CMP + 5'(i))    rd_val = cmp_val[i];
      if (slot == SLOT_RELOAD + 5'(i)) rd_val = reload_val[i];
    end
  end

  assign data_d = rd_en ? (addr_i[2] ? {32'd0, rd_val[63:32]} : rd_val) : data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= '0;
      div_cnt_q  <= '0;
      ctrl_en_q  <= 1'b1;
      ctrl_div_q <= '0;
      data_q     <= '0;
    end else begin
      mtime_q    <= mtime_d;
      div_cnt_q  <= div_cnt_d;
      ctrl_en_q  <= ctrl_en_d;
      ctrl_div_q <= ctrl_div_d;
      data_q     <= data_d;
    end
  end

  for (genvar g = 0; g < NUM_CMP; g++) begin : g_ch
    assign cmp_wr[g]    = wr_en && (slot == SLOT_CMP + 5'(g));
    assign reload_wr[g] = wr_en && (slot == SLOT_RELOAD + 5'(g));

    mtimer_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .mtime_i     (mtime_q),
      .wdata_i     (wd_eff),
      .be_i        (be_eff),
      .cmp_wr_i    (cmp_wr[g]),
      .reload_wr_i (reload_wr[g]),
      .clr_i       (clr_bits[g]),
      .cmp_o       (cmp_val[g]),
      .reload_o    (reload_val[g]),
      .pending_o   (pending[g]),
      .mti_o       (mti[g])
    );
  end

  assign data_o  = data_q;
  assign mti_o   = mti;
  assign mtime_o = mtime_q;

endmodule

// File: tb/tb_mtimer_bank.sv
// tb/tb_mtimer_bank.sv - directed self-checking bench for mtimer_bank
module tb_mtimer_bank;

  localparam int NUM_CMP    = 4;
  localparam int PRESCALE_W = 16;

  logic               clk;
  logic               reset;
  logic               en_i;
  logic [7:0]         addr_i;
  logic [7:0]         we_i;
  logic [63:0]        data_i;
  logic [63:0]        data_o;
  logic [NUM_CMP-1:0] mti_o;
  logic [63:0]        mtime_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] rd;

  mtimer_bank #(.NUM_CMP(NUM_CMP), .PRESCALE_W(PRESCALE_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en_i    (en_i),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .mti_o   (mti_o),
    .mtime_o (mtime_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] w, input logic [63:0] d);
    en_i = 1'b1; addr_i = a; we_i = w; data_i = d;
    @(negedge clk);
    en_i = 1'b0; we_i = 8'd0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [63:0] q);
    en_i = 1'b1; addr_i = a; we_i = 8'd0;
    @(negedge clk);
    en_i = 1'b0;
    q = data_o;
  endtask

  initial begin
    reset = 1'b1; en_i = 1'b0; addr_i = '0; we_i = '0; data_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_mtime", mtime_o, 64'd0);
    check_eq("rst_mti", 64'(mti_o), 64'd0);
    check_eq("rst_data", data_o, 64'd0);
    reset = 1'b0;

    repeat (10) @(negedge clk);
    check_eq("idle_mtime", mtime_o, 64'd10);
    check_eq("idle_mti", 64'(mti_o), 64'd0);
    bus_read(8'h00, rd);
    check_eq("rd_mtime", rd, 64'd10);
    check_eq("mtime_next", mtime_o, 64'd11);

    bus_read(8'h08, rd);  check_eq("rst_ctrl", rd, 64'h1);
    bus_read(8'h24, rd);  check_eq("rst_cmp0_hi", rd, 64'h0000_0000_FFFF_FFFF);
    bus_read(8'h60, rd);  check_eq("rst_reload0", rd, 64'd0);
    bus_read(8'h10, rd);  check_eq("rst_status", rd, 64'd0);

    // prescaler
    bus_write(8'h08, 8'hFF, 64'h0);
    bus_write(8'h00, 8'hFF, 64'h0);
    check_eq("frz_mtime0", mtime_o, 64'd0);
    repeat (5) @(negedge clk);
    check_eq("frz_mtime1", mtime_o, 64'd0);
    bus_write(8'h08, 8'hFF, 64'h0003_0001);
    check_eq("div_t0", mtime_o, 64'd0);
    repeat (3) @(negedge clk);  check_eq("div_t3", mtime_o, 64'd0);
    @(negedge clk);             check_eq("div_t4", mtime_o, 64'd1);
    repeat (3) @(negedge clk);  check_eq("div_t7", mtime_o, 64'd1);
    @(negedge clk);             check_eq("div_t8", mtime_o, 64'd2);
    bus_write(8'h08, 8'hFF, 64'h0003_0000);
    repeat (10) @(negedge clk);
    check_eq("div_frozen", mtime_o, 64'd2);
    bus_read(8'h08, rd);  check_eq("rd_ctrl", rd, 64'h0003_0000);

    // wrap
    bus_write(8'h08, 8'hFF, 64'h1);
    bus_write(8'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("wr_wins", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
    bus_read(8'h04, rd);
    check_eq("rd_hi_pre", rd, 64'h0000_0000_FFFF_FFFF);
    check_eq("mtime_max", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check_eq("mtime_wrap", mtime_o, 64'd0);
    check_eq("mti_eq_max", 64'(mti_o), 64'hF);
    bus_read(8'h04, rd);
    check_eq("rd_hi_wrap", rd, 64'd0);
    check_eq("mti_after_wrap", 64'(mti_o), 64'd0);

    // partial / upper-half writes and unmapped space
    bus_write(8'h24, 8'h0F, 64'hDEAD_BEEF_1234_5678);
    bus_read(8'h20, rd);  check_eq("cmp0_hiwr", rd, 64'h1234_5678_FFFF_FFFF);
    bus_write(8'h20, 8'h01, 64'h1111_1111_1111_11AB);
    bus_read(8'h20, rd);  check_eq("cmp0_bytewr", rd, 64'h1234_5678_FFFF_FFAB);
    bus_read(8'h24, rd);  check_eq("cmp0_hird", rd, 64'h0000_0000_1234_5678);
    bus_write(8'h18, 8'hFF, 64'h1234);
    bus_read(8'h18, rd);  check_eq("unmap_18", rd, 64'd0);
    bus_read(8'h40, rd);  check_eq("unimpl_cmp4", rd, 64'd0);
    bus_read(8'hA0, rd);  check_eq("unmap_a0", rd, 64'd0);

    // channel 1 one-shot
    bus_write(8'h00, 8'hFF, 64'd0);
    bus_write(8'h28, 8'hFF, 64'd20);
    repeat (19) @(negedge clk);
    check_eq("ch1_mtime20", mtime_o, 64'd20);
    check_eq("ch1_mti_lo", 64'(mti_o), 64'd0);
    @(negedge clk);
    check_eq("ch1_mti_rise", 64'(mti_o), 64'h2);
    repeat (4) @(negedge clk);
    check_eq("ch1_mti_hold", 64'(mti_o), 64'h2);

    // channel 0 periodic
    bus_write(8'h00, 8'hFF, 64'd0);
    bus_write(8'h60, 8'hFF, 64'd8);
    bus_write(8'h20, 8'hFF, 64'd5);
    repeat (3) @(negedge clk);
    check_eq("ch0_mtime5", mtime_o, 64'd5);
    check_eq("ch0_mti_lo", 64'(mti_o[0]), 64'd0);
    @(negedge clk);
    bus_read(8'h10, rd);  check_eq("ch0_pend_set", rd, 64'h1);
    check_eq("ch0_mti_hi", 64'(mti_o[0]), 64'd1);
    bus_read(8'h20, rd);  check_eq("ch0_cmp13", rd, 64'd13);
    bus_write(8'h10, 8'h01, 64'h1);
    bus_read(8'h10, rd);  check_eq("ch0_w1c", rd, 64'd0);
    check_eq("ch0_mti_clr", 64'(mti_o[0]), 64'd0);
    repeat (4) @(negedge clk);
    bus_read(8'h10, rd);  check_eq("ch0_pend_13", rd, 64'h1);
    bus_read(8'h20, rd);  check_eq("ch0_cmp21", rd, 64'd21);
    repeat (5) @(negedge clk);
    bus_write(8'h10, 8'h01, 64'h1);
    bus_read(8'h10, rd);  check_eq("set_vs_w1c", rd, 64'h1);
    repeat (6) @(negedge clk);
    bus_write(8'h20, 8'hFF, 64'd100);
    bus_read(8'h20, rd);  check_eq("cmpwr_wins", rd, 64'd100);
    bus_read(8'h10, rd);  check_eq("cmpwr_clr", rd, 64'd0);

    // far-behind compare advances once per cycle
    bus_write(8'h20, 8'hFF, 64'd2);
    @(negedge clk);
    bus_read(8'h20, rd);  check_eq("catch_10", rd, 64'd10);
    bus_read(8'h20, rd);  check_eq("catch_18", rd, 64'd18);
    repeat (3) @(negedge clk);
    bus_read(8'h20, rd);  check_eq("catch_42", rd, 64'd42);

    // reset with a same-cycle write
    reset = 1'b1; en_i = 1'b1; addr_i = 8'h00; we_i = 8'hFF; data_i = 64'h55;
    @(negedge clk);
    reset = 1'b0; en_i = 1'b0; we_i = 8'd0;
    check_eq("mid_rst_mtime", mtime_o, 64'd0);
    check_eq("mid_rst_mti", 64'(mti_o), 64'd0);
    check_eq("mid_rst_data", data_o, 64'd0);
    bus_read(8'h20, rd);  check_eq("mid_rst_cmp0", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_read(8'h60, rd);  check_eq("mid_rst_reload0", rd, 64'd0);
    bus_read(8'h08, rd);  check_eq("mid_rst_ctrl", rd, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
